// File: rtl/axi_slave_mem.sv
// AXI4 slave RAM with FIXED/INCR/WRAP bursts and SLVERR on bad access.
// Define AXI_SLAVE_MEM_WSTRB_EN to add WSTRB byte-lane write enables.
module axi_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    AWREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    input  logic [LEN_WIDTH-1:0]    AWLEN,
    input  logic [1:0]              AWBURST,
    output logic                    WREADY,
    input  logic                    WVALID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
`ifdef AXI_SLAVE_MEM_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
`endif
    input  logic                    WLAST,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    output logic                    ARREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    input  logic [LEN_WIDTH-1:0]    ARLEN,
    input  logic [1:0]              ARBURST,
    input  logic                    RREADY,
    output logic                    RVALID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic                    RLAST,
    output logic [1:0]              RRESP
);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [1:0] B_INCR = 2'b01;
    localparam logic [1:0] B_WRAP = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [IDX_W-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic oob(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (OFF_W + IDX_W)) != '0;
    endfunction

    function automatic logic bad_burst(input logic [1:0] b,
                                       input logic [LEN_WIDTH-1:0] len);
        logic ok_len;
        ok_len = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                 (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
        return (b == 2'b11) || (b == B_WRAP && !ok_len);
    endfunction

    // WRAP blocks are (len+1) words, so len itself is the in-block mask.
    function automatic logic [IDX_W-1:0] next_word(input logic [IDX_W-1:0] w,
                                                   input logic [LEN_WIDTH-1:0] len,
                                                   input logic [1:0] b);
        logic [IDX_W-1:0] mask;
        mask = IDX_W'(len);
        unique case (b)
            2'b00:   return w;
            B_WRAP:  return (w & ~mask) | ((w + 1'b1) & mask);
            default: return w + 1'b1;
        endcase
    endfunction

    w_state_t             w_state;
    logic                 aw_ready, w_ready, b_valid;
    logic [1:0]           b_resp;
    logic [IDX_W-1:0]     wr_word;
    logic [LEN_WIDTH-1:0] wr_len, wr_cnt;
    logic [1:0]           wr_burst;
    logic                 wr_err, wr_bad, wr_over;

    logic w_fire, wr_at_end, wr_mis, wr_en;
    assign w_fire    = WVALID && w_ready;
    assign wr_at_end = (wr_cnt == wr_len) && !wr_over;
    assign wr_mis    = wr_over || (WLAST != wr_at_end);
    assign wr_en     = w_fire && !wr_err && !wr_over && !(WLAST && !wr_at_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= 2'b00;
            wr_word  <= '0;
            wr_len   <= '0;
            wr_cnt   <= '0;
            wr_burst <= 2'b00;
            wr_err   <= 1'b0;
            wr_bad   <= 1'b0;
            wr_over  <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_ready && AWVALID) begin
                        wr_word  <= word_of(AWADDR);
                        wr_len   <= AWLEN;
                        wr_burst <= bad_burst(AWBURST, AWLEN) ? B_INCR : AWBURST;
                        wr_err   <= oob(AWADDR) || bad_burst(AWBURST, AWLEN);
                        wr_bad   <= 1'b0;
                        wr_over  <= 1'b0;
                        wr_cnt   <= '0;
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b1;
                        w_state  <= W_DATA;
                    end else begin
                        aw_ready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_mis) wr_bad <= 1'b1;
                        if (!wr_over) wr_word <= next_word(wr_word, wr_len, wr_burst);
                        if (wr_at_end && !WLAST) wr_over <= 1'b1;
                        if (WLAST) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_resp  <= (wr_err || wr_bad || wr_mis) ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        b_valid  <= 1'b0;
                        b_resp   <= 2'b00;
                        aw_ready <= 1'b1;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
`ifdef AXI_SLAVE_MEM_WSTRB_EN
            for (int i = 0; i < DATA_WIDTH / 8; i++)
                if (WSTRB[i]) mem[wr_word][8*i +: 8] <= WDATA[8*i +: 8];
`else
            mem[wr_word] <= WDATA;
`endif
        end
    end

    r_state_t             r_state;
    logic                 ar_ready, r_valid, r_last;
    logic [1:0]           r_resp;
    logic [IDX_W-1:0]     rd_word;
    logic [LEN_WIDTH-1:0] rd_len, rd_cnt;
    logic [1:0]           rd_burst;
    logic                 rd_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_resp   <= 2'b00;
            rd_word  <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
            rd_burst <= 2'b00;
            rd_err   <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ar_ready && ARVALID) begin
                        rd_word  <= word_of(ARADDR);
                        rd_len   <= ARLEN;
                        rd_burst <= bad_burst(ARBURST, ARLEN) ? B_INCR : ARBURST;
                        rd_err   <= oob(ARADDR) || bad_burst(ARBURST, ARLEN);
                        r_resp   <= (oob(ARADDR) || bad_burst(ARBURST, ARLEN)) ? 2'b10 : 2'b00;
                        rd_cnt   <= '0;
                        r_last   <= (ARLEN == '0);
                        ar_ready <= 1'b0;
                        r_valid  <= 1'b1;
                        r_state  <= R_DATA;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (r_last) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            r_resp   <= 2'b00;
                            ar_ready <= 1'b1;
                            r_state  <= R_IDLE;
                        end else begin
                            rd_word <= next_word(rd_word, rd_len, rd_burst);
                            rd_cnt  <= rd_cnt + 1'b1;
                            r_last  <= (rd_cnt + 1'b1 == rd_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign AWREADY = aw_ready;
    assign WREADY  = w_ready;
    assign BVALID  = b_valid;
    assign BRESP   = b_resp;
    assign ARREADY = ar_ready;
    assign RVALID  = r_valid;
    assign RLAST   = r_last;
    assign RRESP   = r_resp;
    assign RDATA   = (r_valid && !rd_err) ? mem[rd_word] : '0;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, errors, stalls, reset abort.
// Build with AXI_SLAVE_MEM_WSTRB_EN to exercise byte strobes.
module tb_axi_slave_mem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        AWREADY, AWVALID, WREADY, WVALID, WLAST, BREADY, BVALID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        ARREADY, ARVALID, RREADY, RVALID, RLAST;
    logic [3:0]  ws = 4'hF;

    int checks = 0;
    int errors = 0;

    logic [31:0] wd  [16];
    logic [31:0] xd  [16];
    logic [31:0] rdd [16];
    logic [1:0]  rrs [16];
    logic        rls [16];
    logic [1:0]  br;

    always #5 clk = ~clk;

    axi_slave_mem dut (
        .clk(clk), .rst_n(rst_n),
        .AWREADY(AWREADY), .AWADDR(AWADDR), .AWVALID(AWVALID),
        .AWLEN(AWLEN), .AWBURST(AWBURST),
        .WREADY(WREADY), .WVALID(WVALID), .WDATA(WDATA),
`ifdef AXI_SLAVE_MEM_WSTRB_EN
        .WSTRB(ws),
`endif
        .WLAST(WLAST), .BREADY(BREADY), .BRESP(BRESP), .BVALID(BVALID),
        .ARREADY(ARREADY), .ARADDR(ARADDR), .ARVALID(ARVALID),
        .ARLEN(ARLEN), .ARBURST(ARBURST), .RREADY(RREADY),
        .RVALID(RVALID), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nb, input int last_idx,
                            input bit hold_b, output logic [1:0] resp);
        int n;
        @(negedge clk);
        AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready", AWREADY, 1);
        @(negedge clk);
        AWVALID = 1'b0;
        BREADY = !hold_b;
        for (int i = 0; i < nb; i++) begin
            WDATA = wd[i]; WLAST = (i == last_idx); WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin @(negedge clk); n++; end
            chk("w_ready", WREADY, 1);
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0;
        while (!BVALID && n < 50) begin @(negedge clk); n++; end
        chk("b_valid", BVALID, 1);
        if (hold_b) begin
            repeat (5) begin
                chk("b_hold_valid", BVALID, 1);
                chk("b_hold_awready", AWREADY, 0);
                @(negedge clk);
            end
            BREADY = 1'b1;
        end
        resp = BRESP;
        @(negedge clk);
        chk("b_done", BVALID, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle);
        int n, beat, cyc;
        bit held;
        logic [31:0] hd;
        logic [1:0]  hr;
        logic        hl;
        @(negedge clk);
        ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready", ARREADY, 1);
        @(negedge clk);
        ARVALID = 1'b0;
        beat = 0; cyc = 0; held = 0;
        while (beat <= int'(len) && cyc < 300) begin
            RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
            if (held) begin
                chk("hold_rdata", RDATA, hd);
                chk("hold_rresp", 32'(RRESP), 32'(hr));
                chk("hold_rlast", 32'(RLAST), 32'(hl));
                held = 0;
            end
            if (RVALID && RREADY) begin
                rdd[beat] = RDATA; rrs[beat] = RRESP; rls[beat] = RLAST;
                beat++;
            end else if (RVALID) begin
                hd = RDATA; hr = RRESP; hl = RLAST; held = 1;
            end
            @(negedge clk);
            cyc++;
        end
        RREADY = 1'b1;
        chk("r_beats", beat, int'(len) + 1);
        chk("r_done", RVALID, 0);
    endtask

    task automatic chk_rd(input string tag, input int n, input logic [1:0] resp);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_d%0d", tag, i), rdd[i], xd[i]);
            chk($sformatf("%s_r%0d", tag, i), 32'(rrs[i]), 32'(resp));
            chk($sformatf("%s_l%0d", tag, i), 32'(rls[i]), 32'(i == n - 1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        AWADDR = '0; AWVALID = 0; AWLEN = '0; AWBURST = '0;
        WVALID = 0; WDATA = '0; WLAST = 0; BREADY = 1;
        ARADDR = '0; ARVALID = 0; ARLEN = '0; ARBURST = '0; RREADY = 1;
        repeat (3) @(negedge clk);
        chk("rst_awready", AWREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rdata", RDATA, 0);
        rst_n = 1'b1;
        #1 chk("rel_awready_pre", AWREADY, 0);
        @(negedge clk);
        chk("rel_awready", AWREADY, 1);
        chk("rel_arready", ARREADY, 1);

        // INCR write then read back
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
        do_write(32'h10, 3, 2'b01, 4, 3, 0, br);
        chk("incr_bresp", 32'(br), 0);
        do_read(32'h10, 3, 2'b01, 0);
        for (int i = 0; i < 4; i++) xd[i] = 32'hA0 + i;
        chk_rd("incr", 4, 2'b00);

        // WRAP 4 beats from word 6: 6,7,4,5
        do_read(32'h18, 3, 2'b10, 0);
        xd[0] = 32'hA2; xd[1] = 32'hA3; xd[2] = 32'hA0; xd[3] = 32'hA1;
        chk_rd("wrap", 4, 2'b00);

        // FIXED write keeps only the last beat
        for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + i;
        do_write(32'h40, 3, 2'b00, 4, 3, 0, br);
        chk("fixed_bresp", 32'(br), 0);
        do_read(32'h40, 0, 2'b01, 0);
        xd[0] = 32'hB3;
        chk_rd("fixed", 1, 2'b00);

        // out-of-range read
        do_read(32'd4096, 3, 2'b01, 0);
        for (int i = 0; i < 4; i++) xd[i] = 32'h0;
        chk_rd("oob", 4, 2'b10);

        // early WLAST
        for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + i;
        do_write(32'h80, 3, 2'b01, 4, 3, 0, br);
        wd[0] = 32'hC0; wd[1] = 32'hD1;
        do_write(32'h80, 3, 2'b01, 2, 1, 0, br);
        chk("early_bresp", 32'(br), 2);
        do_read(32'h80, 3, 2'b01, 0);
        for (int i = 0; i < 4; i++) xd[i] = 32'hC0 + i;
        chk_rd("early", 4, 2'b00);

        // extra beats beyond AWLEN are dropped
        wd[0] = 32'h0; wd[1] = 32'h0; wd[2] = 32'hF2;
        do_write(32'hC0, 2, 2'b01, 3, 2, 0, br);
        wd[0] = 32'hE0; wd[1] = 32'hE1; wd[2] = 32'hE2;
        do_write(32'hC0, 1, 2'b01, 3, 2, 0, br);
        chk("extra_bresp", 32'(br), 2);
        do_read(32'hC0, 2, 2'b01, 0);
        xd[0] = 32'hE0; xd[1] = 32'hE1; xd[2] = 32'hF2;
        chk_rd("extra", 3, 2'b00);

        // reserved burst write is suppressed
        wd[0] = 32'hDEAD;
        do_write(32'h10, 0, 2'b11, 1, 0, 0, br);
        chk("rsv_bresp", 32'(br), 2);
        do_read(32'h10, 0, 2'b01, 0);
        xd[0] = 32'hA0;
        chk_rd("rsv", 1, 2'b00);

        // WRAP with illegal length
        do_read(32'h10, 2, 2'b10, 0);
        for (int i = 0; i < 3; i++) xd[i] = 32'h0;
        chk_rd("badwrap", 3, 2'b10);

        // RREADY toggling
        do_read(32'h10, 3, 2'b01, 1);
        for (int i = 0; i < 4; i++) xd[i] = 32'hA0 + i;
        chk_rd("stall", 4, 2'b00);

        // INCR wraps modulo depth
        wd[0] = 32'h6060; wd[1] = 32'h6161;
        do_write(32'hFFC, 1, 2'b01, 2, 1, 0, br);
        chk("modw_bresp", 32'(br), 0);
        do_read(32'h0, 0, 2'b01, 0);
        xd[0] = 32'h6161;
        chk_rd("modw", 1, 2'b00);

        // concurrent read and write, B held off
        for (int i = 0; i < 8; i++) wd[i] = 32'h200 + i;
        do_write(32'h200, 7, 2'b01, 8, 7, 0, br);
        for (int i = 0; i < 8; i++) wd[i] = 32'h100 + i;
        fork
            do_write(32'h100, 7, 2'b01, 8, 7, 1, br);
            do_read(32'h200, 7, 2'b01, 0);
        join
        chk("conc_bresp", 32'(br), 0);
        for (int i = 0; i < 8; i++) xd[i] = 32'h200 + i;
        chk_rd("conc_rd", 8, 2'b00);
        do_read(32'h100, 7, 2'b01, 0);
        for (int i = 0; i < 8; i++) xd[i] = 32'h100 + i;
        chk_rd("conc_wr", 8, 2'b00);

`ifdef AXI_SLAVE_MEM_WSTRB_EN
        ws = 4'hF; wd[0] = 32'h11223344;
        do_write(32'h300, 0, 2'b01, 1, 0, 0, br);
        ws = 4'b0101; wd[0] = 32'hAABBCCDD;
        do_write(32'h300, 0, 2'b01, 1, 0, 0, br);
        ws = 4'hF;
        do_read(32'h300, 0, 2'b01, 0);
        xd[0] = 32'h11BB33DD;
        chk_rd("wstrb", 1, 2'b00);
`endif

        // reset mid-burst on both channels
        @(negedge clk);
        AWADDR = 32'h380; AWLEN = 3; AWBURST = 2'b01; AWVALID = 1;
        @(negedge clk);
        AWVALID = 0;
        WVALID = 1; WDATA = 32'h48480000; WLAST = 0;
        ARADDR = 32'h200; ARLEN = 7; ARBURST = 2'b01; ARVALID = 1;
        @(negedge clk);
        WVALID = 0; ARVALID = 0; RREADY = 1;
        @(negedge clk);
        chk("pre_rst_wready", WREADY, 1);
        chk("pre_rst_rvalid", RVALID, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_awready", AWREADY, 0);
        chk("mid_rst_wready", WREADY, 0);
        chk("mid_rst_bvalid", BVALID, 0);
        chk("mid_rst_bresp", 32'(BRESP), 0);
        chk("mid_rst_arready", ARREADY, 0);
        chk("mid_rst_rvalid", RVALID, 0);
        chk("mid_rst_rlast", RLAST, 0);
        chk("mid_rst_rresp", 32'(RRESP), 0);
        chk("mid_rst_rdata", RDATA, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_read(32'h380, 0, 2'b01, 0);
        xd[0] = 32'h48480000;
        chk_rd("kept", 1, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
